instruction_fetch: RTL and testbench

//  - Fetch stage upstream of the instruction memory: owns the program counter and drives the byte address.
//  - Captures the 32-bit instruction returned combinationally in the same cycle.
//  - Buffers each captured {pc, instr} pair in a small FIFO and hands it to decode over a valid/ready handshake.
//  - Accepts redirects (branch/jump targets) that flush the FIFO and restart fetch at the target.

---
 rtl/fetch_pkg.sv | 12 +
 rtl/instruction_fetch_if.sv | 36 +++
 rtl/fetch_fifo.sv | 68 ++++++
 rtl/instruction_fetch.sv | 91 +++++++++
 tb/tb_instruction_fetch.sv | 233 +++++++++++++++++++++++
 5 files changed

// File: rtl/fetch_pkg.sv
// Shared fetch-stage definitions: instruction size, pc increment and the buffered entry type.
package fetch_pkg;

    localparam int INSTR_BYTES = 4;
    localparam int PC_INC      = 4;

    typedef struct packed {
        logic [63:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/instruction_fetch_if.sv
// Fetch-stage bus: instruction memory address/data, redirect input and the decode handshake.
interface instruction_fetch_if #(
    parameter int PC_WIDTH    = 64,
    parameter int INSTR_WIDTH = 32
);
    logic [PC_WIDTH-1:0]    imem_addr;
    logic [INSTR_WIDTH-1:0] imem_instr;
    logic                   redirect_valid;
    logic [PC_WIDTH-1:0]    redirect_target;
    logic                   out_valid;
    logic                   out_ready;
    logic [PC_WIDTH-1:0]    out_pc;
    logic [INSTR_WIDTH-1:0] out_instr;

    modport master (
        output imem_addr,
        input  imem_instr,
        input  redirect_valid,
        input  redirect_target,
        output out_valid,
        input  out_ready,
        output out_pc,
        output out_instr
    );

    modport slave (
        input  imem_addr,
        output imem_instr,
        output redirect_valid,
        output redirect_target,
        input  out_valid,
        output out_ready,
        input  out_pc,
        input  out_instr
    );
endinterface

// File: rtl/fetch_fifo.sv
// Small power-of-two FIFO holding fetched {pc, instr} entries; flush empties it in one cycle.
module fetch_fifo #(
    parameter int QDEPTH = 2,
    parameter int WIDTH  = 96
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        push,
    input  logic                        pop,
    input  logic                        flush,
    input  logic [WIDTH-1:0]            wdata,
    output logic [WIDTH-1:0]            rdata,
    output logic [$clog2(QDEPTH+1)-1:0] count
);
    localparam int PTR_W = $clog2(QDEPTH);
    localparam int CNT_W = $clog2(QDEPTH+1);

    logic [WIDTH-1:0] mem [QDEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count_q;
    logic [WIDTH-1:0] last_q;
    logic             nonempty;
    logic             do_pop;
    logic             do_push;

    assign nonempty = (count_q != '0);
    assign do_pop   = pop & nonempty;
    assign do_push  = push & ((count_q != CNT_W'(QDEPTH)) | do_pop);

    // When empty the head output keeps showing the last entry that was presented.
    assign rdata = nonempty ? mem[rd_ptr] : last_q;
    assign count = count_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
            last_q  <= '0;
            for (int i = 0; i < QDEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (nonempty) begin
                last_q <= mem[rd_ptr];
            end
            if (flush) begin
                wr_ptr  <= '0;
                rd_ptr  <= '0;
                count_q <= '0;
            end else begin
                if (do_push) begin
                    mem[wr_ptr] <= wdata;
                    wr_ptr      <= wr_ptr + PTR_W'(1);
                end
                if (do_pop) begin
                    rd_ptr <= rd_ptr + PTR_W'(1);
                end
                case ({do_push, do_pop})
                    2'b10:   count_q <= count_q + CNT_W'(1);
                    2'b01:   count_q <= count_q - CNT_W'(1);
                    default: count_q <= count_q;
                endcase
            end
        end
    end
endmodule

// File: rtl/instruction_fetch.sv
// Fetch stage: pc register, next-pc mux and decode handshake around fetch_fifo.
// Optional macro FETCH_PERF_CNT_EN adds fetch_count / redirect_count outputs.
module instruction_fetch
    import fetch_pkg::*;
#(
    parameter int                  PC_WIDTH    = 64,
    parameter int                  INSTR_WIDTH = 32,
    parameter logic [PC_WIDTH-1:0] RESET_PC    = '0,
    parameter int                  QDEPTH      = 2
) (
    input  logic                clk,
    input  logic                reset,
    instruction_fetch_if.master bus
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0]         fetch_count,
    output logic [31:0]         redirect_count
`endif
);
    localparam int ALIGN_BITS = $clog2(INSTR_BYTES);
    localparam int ENTRY_W    = PC_WIDTH + INSTR_WIDTH;
    localparam int CNT_W      = $clog2(QDEPTH+1);

    logic [PC_WIDTH-1:0] pc;
    logic [PC_WIDTH-1:0] pc_next;
    logic [PC_WIDTH-1:0] target_aligned;
    logic [ENTRY_W-1:0]  head;
    logic [CNT_W-1:0]    count;
    logic                full;
    logic                push;
    logic                pop;

    assign full          = (count == CNT_W'(QDEPTH));
    assign bus.out_valid = (count != '0);
    assign pop           = bus.out_valid & bus.out_ready;
    assign push          = ~bus.redirect_valid & (~full | pop);

    assign target_aligned = {bus.redirect_target[PC_WIDTH-1:ALIGN_BITS], ALIGN_BITS'(0)};

    always_comb begin
        pc_next = pc;
        if (bus.redirect_valid) begin
            pc_next = target_aligned;
        end else if (push) begin
            pc_next = pc + PC_WIDTH'(PC_INC);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc <= RESET_PC;
        end else begin
            pc <= pc_next;
        end
    end

    assign bus.imem_addr = pc;

    fetch_fifo #(
        .QDEPTH (QDEPTH),
        .WIDTH  (ENTRY_W)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .flush (bus.redirect_valid),
        .wdata ({pc, bus.imem_instr}),
        .rdata (head),
        .count (count)
    );

    assign bus.out_pc    = head[ENTRY_W-1:INSTR_WIDTH];
    assign bus.out_instr = head[INSTR_WIDTH-1:0];

`ifdef FETCH_PERF_CNT_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_count    <= '0;
            redirect_count <= '0;
        end else begin
            if (push) begin
                fetch_count <= fetch_count + 32'd1;
            end
            if (bus.redirect_valid) begin
                redirect_count <= redirect_count + 32'd1;
            end
        end
    end
`endif
endmodule

// File: tb/tb_instruction_fetch.sv
// Bench for instruction_fetch: directed vector table, wrap check on a second instance, random run vs queue model.
module tb_instruction_fetch;
    import fetch_pkg::*;

    localparam int          QD   = 2;
    localparam logic [63:0] RPC2 = 64'hFFFF_FFFF_FFFF_FFF8;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    instruction_fetch_if #(.PC_WIDTH(64), .INSTR_WIDTH(32)) bus ();
    instruction_fetch_if #(.PC_WIDTH(64), .INSTR_WIDTH(32)) bus2 ();

    assign bus.imem_instr       = 32'hA000_0000 | bus.imem_addr[31:0];
    assign bus2.imem_instr      = 32'hA000_0000 | bus2.imem_addr[31:0];
    assign bus2.redirect_valid  = 1'b0;
    assign bus2.redirect_target = '0;
    assign bus2.out_ready       = 1'b1;

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] fc, rc, fc2, rc2;
`endif

    instruction_fetch #(
        .PC_WIDTH(64), .INSTR_WIDTH(32), .RESET_PC(64'h0), .QDEPTH(QD)
    ) dut (
        .clk(clk), .reset(reset), .bus(bus)
`ifdef FETCH_PERF_CNT_EN
        , .fetch_count(fc), .redirect_count(rc)
`endif
    );

    instruction_fetch #(
        .PC_WIDTH(64), .INSTR_WIDTH(32), .RESET_PC(RPC2), .QDEPTH(QD)
    ) dut2 (
        .clk(clk), .reset(reset), .bus(bus2)
`ifdef FETCH_PERF_CNT_EN
        , .fetch_count(fc2), .redirect_count(rc2)
`endif
    );

    int vectors = 0;
    int miscompares = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: a plain queue of fetched entries plus the fetch pointer.
    fetch_entry_t mq[$];
    logic [63:0]  mpc;
    fetch_entry_t mlast;
    logic [31:0]  mfc, mrc;
    bit           mon = 0;

    task automatic model_update(input logic r, input logic rv, input logic [63:0] t, input logic rd);
        bit pop_m, push_m;
        fetch_entry_t e;
        if (r) begin
            mq.delete();
            mpc   = 64'h0;
            mlast = '0;
            mfc   = '0;
            mrc   = '0;
            mon   = 1;
        end else if (mon) begin
            pop_m = (mq.size() != 0) && rd;
            if (mq.size() != 0) mlast = mq[0];
            if (rv) begin
                mq.delete();
                mpc = t & ~64'h3;
                mrc = mrc + 1;
            end else begin
                push_m = (mq.size() < QD) || pop_m;
                if (pop_m) void'(mq.pop_front());
                if (push_m) begin
                    e.pc    = mpc;
                    e.instr = 32'hA000_0000 | mpc[31:0];
                    mq.push_back(e);
                    mpc = mpc + 64'd4;
                    mfc = mfc + 1;
                end
            end
        end
    endtask

    task automatic model_check();
        fetch_entry_t h;
        if (!mon) return;
        h = (mq.size() != 0) ? mq[0] : mlast;
        chk("m_valid", {63'd0, bus.out_valid}, {63'd0, (mq.size() != 0)});
        chk("m_pc", bus.out_pc, h.pc);
        chk("m_instr", {32'd0, bus.out_instr}, {32'd0, h.instr});
        chk("m_addr", bus.imem_addr, mpc);
`ifdef FETCH_PERF_CNT_EN
        chk("m_fetch_count", {32'd0, fc}, {32'd0, mfc});
        chk("m_redirect_count", {32'd0, rc}, {32'd0, mrc});
`endif
    endtask

    task automatic apply(input logic r, input logic rv, input logic [63:0] t, input logic rd);
        reset               = r;
        bus.redirect_valid  = rv;
        bus.redirect_target = t;
        bus.out_ready       = rd;
        @(negedge clk);
        model_check();
    endtask

    task automatic advance(input logic r, input logic rv, input logic [63:0] t, input logic rd);
        @(posedge clk);
        model_update(r, rv, t, rd);
        #1;
    endtask

    typedef struct {
        logic        rst;
        logic        rv;
        logic [63:0] tgt;
        logic        rdy;
        logic        chk;
        logic        ev;
        logic [63:0] epc;
        logic [63:0] eaddr;
    } vec_t;

    vec_t tq[$];

    task automatic add(input logic rst, input logic rv, input logic [63:0] tgt, input logic rdy,
                       input logic c, input logic ev, input logic [63:0] epc, input logic [63:0] eaddr);
        vec_t v;
        v.rst = rst; v.rv = rv; v.tgt = tgt; v.rdy = rdy;
        v.chk = c; v.ev = ev; v.epc = epc; v.eaddr = eaddr;
        tq.push_back(v);
    endtask

    initial begin
        logic [31:0] ei;
        logic [63:0] exp_pc;
        logic [63:0] rt;
        logic        rr, rrv, rrd;

        reset = 1'b1;
        bus.redirect_valid  = 1'b0;
        bus.redirect_target = '0;
        bus.out_ready       = 1'b1;

        // reset state, then streaming with out_ready=1
        add(1,0,64'h0,1, 0,0,64'h0,64'h0);
        add(1,0,64'h0,1, 1,0,64'h0,64'h0);
        add(0,0,64'h0,1, 1,0,64'h0,64'h0);
        add(0,0,64'h0,1, 1,1,64'h0,64'h4);
        add(0,0,64'h0,1, 1,1,64'h4,64'h8);
        add(0,0,64'h0,1, 1,1,64'h8,64'hC);
        // back-pressure: fills to two entries, pc stalls at 8
        add(1,0,64'h0,1, 0,0,64'h0,64'h0);
        add(0,0,64'h0,0, 1,0,64'h0,64'h0);
        add(0,0,64'h0,0, 1,1,64'h0,64'h4);
        add(0,0,64'h0,0, 1,1,64'h0,64'h8);
        add(0,0,64'h0,0, 1,1,64'h0,64'h8);
        add(0,0,64'h0,0, 1,1,64'h0,64'h8);
        add(0,0,64'h0,1, 1,1,64'h0,64'h8);
        add(0,0,64'h0,1, 1,1,64'h4,64'hC);
        add(0,0,64'h0,1, 1,1,64'h8,64'h10);
        // redirect to unaligned target 0x103
        add(0,1,64'h103,1, 1,1,64'hC,64'h14);
        add(0,0,64'h0,1,   1,0,64'hC,64'h100);
        add(0,0,64'h0,1,   1,1,64'h100,64'h104);
        add(0,0,64'h0,1,   1,1,64'h104,64'h108);
        // redirect while full with out_ready=1
        add(0,0,64'h0,0,   1,1,64'h108,64'h10C);
        add(0,1,64'h200,1, 1,1,64'h108,64'h110);
        add(0,0,64'h0,1,   1,0,64'h108,64'h200);
        add(0,0,64'h0,1,   1,1,64'h200,64'h204);
        // reset mid-stream with FIFO full
        add(0,0,64'h0,0, 1,1,64'h204,64'h208);
        add(0,0,64'h0,0, 1,1,64'h204,64'h20C);
        add(1,0,64'h0,1, 1,1,64'h204,64'h20C);
        add(0,0,64'h0,1, 1,0,64'h0,64'h0);
        add(0,0,64'h0,1, 1,1,64'h0,64'h4);

        foreach (tq[i]) begin
            apply(tq[i].rst, tq[i].rv, tq[i].tgt, tq[i].rdy);
            if (tq[i].chk) begin
                ei = (!tq[i].ev && tq[i].epc == 64'h0) ? 32'h0 : (32'hA000_0000 | tq[i].epc[31:0]);
                chk("t_valid", {63'd0, bus.out_valid}, {63'd0, tq[i].ev});
                chk("t_pc", bus.out_pc, tq[i].epc);
                chk("t_instr", {32'd0, bus.out_instr}, {32'd0, ei});
                chk("t_addr", bus.imem_addr, tq[i].eaddr);
            end
            advance(tq[i].rst, tq[i].rv, tq[i].tgt, tq[i].rdy);
        end

        // pc wrap on an instance reset near the top of the address space
        apply(1, 0, 64'h0, 1);
        advance(1, 0, 64'h0, 1);
        for (int i = 0; i < 5; i++) begin
            apply(0, 0, 64'h0, 1);
            if (i == 0) begin
                chk("w_valid0", {63'd0, bus2.out_valid}, 64'd0);
            end else begin
                exp_pc = RPC2 + 64'(4 * (i - 1));
                chk("w_valid", {63'd0, bus2.out_valid}, 64'd1);
                chk("w_pc", bus2.out_pc, exp_pc);
                chk("w_instr", {32'd0, bus2.out_instr}, {32'd0, 32'hA000_0000 | exp_pc[31:0]});
            end
`ifdef FETCH_PERF_CNT_EN
            chk("w_fetch_count", {32'd0, fc2}, 64'(i));
            chk("w_redirect_count", {32'd0, rc2}, 64'd0);
`endif
            advance(0, 0, 64'h0, 1);
        end

        // randomized traffic against the queue model
        for (int n = 0; n < 800; n++) begin
            rr  = ($urandom_range(0, 63) == 0);
            rrv = ($urandom_range(0, 7) == 0);
            rrd = ($urandom_range(0, 3) != 0);
            rt  = {$urandom, $urandom};
            if ($urandom_range(0, 3) == 0) rt = {32'hFFFF_FFFF, 28'hFFF_FFFF, rt[3:0]};
            apply(rr, rrv, rt, rrd);
            advance(rr, rrv, rt, rrd);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
